// File: rtl/uart_rx_monitor.sv
// Oversampling UART receive monitor: configurable frame format, receive FIFO,
// sticky error flags and a run-of-terminators detector.
module uart_rx_monitor #(
   parameter int         DIV        = 27,
   parameter int         OVRSAMP    = 16,
   parameter int         DATA_BITS  = 8,
   parameter int         PARITY     = 0,
   parameter int         STOP_BITS  = 1,
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] TERM_CHAR  = 8'hFF,
   parameter int         TERM_COUNT = 1
) (
   input  logic                          clk,
   input  logic                          nrst,
   input  logic                          rxd,
   input  logic                          rd,
   input  logic                          clr,
   output logic [7:0]                    data_out,
   output logic                          data_vld,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          overflow,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          term
);

   localparam int   DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int   OS_W    = $clog2(OVRSAMP);
   localparam int   PTR_W   = $clog2(FIFO_DEPTH);
   localparam int   CNT_W   = PTR_W + 1;
   localparam int   RUN_W   = $clog2(TERM_COUNT + 1);
   localparam logic ODD_PAR = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
   } state_t;

   state_t               state, state_nxt;
   logic [1:0]           sync;
   logic                 rx_s, rx_prev, start_edge;
   logic [DIV_W-1:0]     div_cnt;
   logic [OS_W-1:0]      os_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 bad_par, bad_frm;
   logic                 tick, smp_start, smp_bit, last_bit, par_mismatch;
   logic                 done, is_term, good, push_req, push, pop, full, drop;
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [RUN_W-1:0]     run_cnt;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

   // Two-flop synchroniser plus one more stage for falling-edge detection.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync    <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         // NOTE: non-blocking so each stage takes the previous stage's old value.
         sync    <= {sync[0], rxd};
         rx_prev <= sync[1];
      end
   end

   assign rx_s       = sync[1];
   assign start_edge = rx_prev & ~rx_s;

   assign tick      = (state != S_IDLE) && (div_cnt == DIV_W'(DIV - 1));
   assign smp_start = tick && (state == S_START) && (os_cnt == OS_W'(OVRSAMP / 2 - 1));
   assign smp_bit   = tick && (state inside {S_DATA, S_PARITY, S_STOP})
                      && (os_cnt == OS_W'(OVRSAMP - 1));
   assign last_bit  = (state == S_DATA) ? (bit_cnt == 4'(DATA_BITS - 1)) :
                      (state == S_STOP) ? (bit_cnt == 4'(STOP_BITS - 1)) : 1'b1;
   assign par_mismatch = (^{shreg, rx_s}) != ODD_PAR;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         S_IDLE:   if (start_edge) state_nxt = S_START;
         S_START:  if (smp_start) state_nxt = rx_s ? S_IDLE : S_DATA;
         S_DATA:   if (smp_bit && last_bit) state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (smp_bit) state_nxt = S_STOP;
         S_STOP:   if (smp_bit && last_bit) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Timing counters are held in IDLE so ticks are phase-aligned to the start edge.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         div_cnt <= '0;
         os_cnt  <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         bad_par <= 1'b0;
         bad_frm <= 1'b0;
      end else begin
         div_cnt <= (state == S_IDLE || tick) ? '0 : div_cnt + DIV_W'(1);
         if (state == S_IDLE)
            os_cnt <= '0;
         else if (tick)
            os_cnt <= (smp_start || smp_bit) ? '0 : os_cnt + OS_W'(1);
         if (state == S_IDLE)
            bit_cnt <= '0;
         else if (smp_bit)
            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
         if (smp_bit && state == S_DATA)
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
         if (state == S_IDLE) begin
            bad_par <= 1'b0;
            bad_frm <= 1'b0;
         end else if (smp_bit) begin
            if (state == S_PARITY && par_mismatch) bad_par <= 1'b1;
            if (state == S_STOP && !rx_s)          bad_frm <= 1'b1;
         end
      end
   end

   assign done     = (state == S_DONE);
   assign good     = ~bad_frm & ~bad_par;
   assign is_term  = (shreg == TERM_CHAR[DATA_BITS-1:0]);
   assign push_req = done & good & ~is_term;
   assign full     = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   assign pop      = rd & data_vld;
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   // NOTE: storage has no reset; only pointers and count need a known state.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
         else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
   end

   assign data_vld = (fifo_cnt != '0);
   assign data_out = data_vld ? 8'(mem[rd_ptr]) : 8'h00;

   // Sticky flags: a set event in the same cycle as clr wins.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         overflow   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         term       <= 1'b0;
         run_cnt    <= '0;
      end else begin
         overflow   <= drop                        | (overflow   & ~clr);
         frame_err  <= (done & bad_frm)            | (frame_err  & ~clr);
         parity_err <= (done & ~bad_frm & bad_par) | (parity_err & ~clr);
         term       <= (done & good & is_term & (run_cnt >= RUN_W'(TERM_COUNT - 1)))
                       | (term & ~clr);
         if (done) begin
            if (!good || !is_term)
               run_cnt <= '0;
            else if (run_cnt != RUN_W'(TERM_COUNT))
               run_cnt <= run_cnt + RUN_W'(1);
         end
      end
   end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
Parametrised UART receive monitor for the verilated SoC top and for FPGA debug builds. It watches a serial line (normally the SoC TxD) with its own baud generator and oversampling receiver. Decoded characters are buffered in a FIFO and reported with error flags. A configurable run of terminator characters raises a sticky end-of-run flag, which the testbench uses to stop simulation. It replaces the fixed 8N1 brgen/rx pair, adding frame-format parameters, buffering, error detection and a multi-character terminator.

Parameters:
DIV, 27, system clocks per oversample tick (>=1)
OVRSAMP, 16, oversample ticks per bit (even, >=4)
DATA_BITS, 8, data bits per frame (5..8)
PARITY, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, stop bits checked (1 or 2)
FIFO_DEPTH, 16, receive FIFO entries (power of 2, >=2)
TERM_CHAR, 8'hFF, terminator character (compared on DATA_BITS LSBs)
TERM_COUNT, 1, consecutive terminators required to assert term (>=1)

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
rxd  in  1  serial input, idle high, asynchronous to clk
rd  in  1  pop request for FIFO head
clr  in  1  synchronous clear of sticky flags (overflow, frame_err, parity_err, term)
data_out  out  8  FIFO head character, zero-extended above DATA_BITS
data_vld  out  1  FIFO non-empty
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: a good character was dropped because the FIFO was full
frame_err  out  1  sticky: a stop bit was sampled low
parity_err  out  1  sticky: parity mismatch
term  out  1  sticky: TERM_COUNT consecutive terminators received

Behaviour:
- Reset (nrst low, async): all outputs 0, FSM IDLE, FIFO empty, counters 0, synchroniser flops set to 1. Reset mid-frame abandons the frame; nothing is pushed.
- rxd passes through a 2-flop synchroniser. Latency from rxd to sampled value is 2 clocks.
- Tick generator: a counter counts 0..DIV-1 and pulses tick on wrap. It is held at 0 in IDLE and restarts on the start edge, so ticks are phase-aligned to the start bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: falling edge of the synchronised rxd -> START, with the oversample counter at 0.
  - START: at tick OVRSAMP/2-1 (mid-bit), rxd=1 -> IDLE (glitch rejected, no flag); rxd=0 -> DATA.
  - DATA: sample each bit at mid-bit, every OVRSAMP ticks, LSB first. After DATA_BITS samples -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: sample one bit. Odd mode requires an odd count of ones over data plus parity; even mode requires an even count. A mismatch marks the frame bad_par.
  - STOP: sample STOP_BITS bits. Any 0 marks the frame bad_frm.
  - DONE: a single cycle, then -> IDLE. The next start edge is accepted from the cycle after DONE. Because DONE follows the mid-bit sample of the last stop bit, the half stop bit that remains is sufficient margin.
- DONE actions:
  - bad_frm: set frame_err, discard the character, reset the terminator run.
  - else bad_par: set parity_err, discard the character, reset the terminator run.
  - else the character equals TERM_CHAR: increment the run counter, saturating at TERM_COUNT. When it reaches TERM_COUNT, set term. Terminators are never pushed.
  - else: clear the run counter and push. If the FIFO is full and rd is not asserted this cycle, drop the character and set overflow.
- FIFO:
  - Data read is first-word fall-through: data_out is valid whenever data_vld=1.
  - rd with data_vld=0 is ignored.
  - A push and a pop in the same cycle both take effect and fifo_cnt is unchanged, including when the FIFO is full.
  - Pointers wrap modulo FIFO_DEPTH. fifo_cnt reaches FIFO_DEPTH when full.
- Sticky flags:
  - clr takes effect on the next edge.
  - If clr coincides with a new set event, the set wins.
  - clr does not affect the FIFO or the terminator run counter.
- Bit period is DIV*OVRSAMP clocks. With the defaults, 27*16=432.

Test Plan:
- DIV=2, OVRSAMP=16 (32 clk/bit), 8N1. Send 0x41, 0x0A -> data_vld rises about 300 clocks after the start edge of 0x41. FIFO yields 0x41 then 0x0A, and all flags stay 0.
- Drive a 10-clock low glitch on rxd while IDLE -> no push, no flags, FSM back in IDLE. A valid 0x55 sent immediately after is received correctly.
- PARITY=2. Send 0x07 with parity bit 0 -> parity_err=1, fifo_cnt=0. Send 0x07 with parity bit 1 -> pushed, and parity_err stays 1 until clr. Send a frame with the stop bit low -> frame_err=1, nothing pushed.
- FIFO_DEPTH=4, rd=0. Send 5 characters -> fifo_cnt=4 and overflow=1, and the FIFO holds the first 4 characters. With the FIFO full, assert rd exactly in the 5th character's DONE cycle -> no overflow, fifo_cnt stays 4.
- TERM_COUNT=2. Send 0xFF, 0x31, 0xFF -> term=0 and only 0x31 is pushed. Then send 0xFF -> term=1. Assert clr -> term=0.
- Assert nrst low in the middle of DATA for 0x5A, release it, then send 0x33 -> the FIFO contains only 0x33 and all outputs were 0 during reset.
